reorder_buffer: RTL and testbench

- 16-entry circular reorder buffer between rename/dispatch (allocation) and architectural retirement.
- Allocates one entry per cycle in program order and hands out the 4-bit ROB tag carried in the RS issue packet.
- Marks entries done on execution writeback and commits one entry per cycle in order; commit returns the stale physical register to the free list.
- Triggers a full pipeline flush when a mispredicted branch reaches the head.

---
 rtl/pipeline_types_pkg.sv | 31 +++
 rtl/reorder_buffer.sv | 156 +++++++++++++++
 tb/tb_reorder_buffer.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_types_pkg.sv
// pipeline_types: shared pipeline typedefs and sizing constants.
//   ROB_DEPTH / ROB_TAG_W size the reorder buffer; PREG_W is the physical
//   register tag width. rob_entry_t is one reorder-buffer slot and
//   rs_issue_pkt_t is the reservation-station issue packet, whose rob_tag
//   width follows ROB_TAG_W.
package pipeline_types;

  localparam int ROB_DEPTH = 16;
  localparam int ROB_TAG_W = 4;
  localparam int PREG_W    = 6;

  typedef struct packed {
    logic              valid;
    logic              done;
    logic              mispredicted;
    logic              is_branch;
    logic              reg_write;
    logic [4:0]        rd_log;
    logic [PREG_W-1:0] rd_phys;
    logic [PREG_W-1:0] rd_old_phys;
    logic [31:0]       pc;
  } rob_entry_t;

  typedef struct packed {
    logic                 valid;
    logic [ROB_TAG_W-1:0] rob_tag;
    logic [PREG_W-1:0]    rd_phys;
    logic [31:0]          pc;
  } rs_issue_pkt_t;

endpackage

// File: rtl/reorder_buffer.sv
// reorder_buffer: DEPTH-entry circular reorder buffer.
//   Allocation side : alloc_valid/alloc_ready handshake, alloc_* entry fields,
//                     alloc_tag = tail pointer handed to the RS issue packet.
//   Writeback side  : wb_valid/wb_tag/wb_mispredict mark an entry done.
//   Commit side     : commit_* mirror the head entry while it is done; the
//                     stale physical register is returned via commit_rd_old_phys.
//   Flush side      : flush_valid/flush_pc pulse when a mispredicted branch
//                     commits; all entries are discarded at that edge.
//   clk, reset      : clock and synchronous active-high reset.
// Optional build macro ROB_PERF_CNT_EN adds saturating 32-bit counters
// perf_commit_cnt, perf_flush_cnt and perf_full_cycles.
module reorder_buffer
  import pipeline_types::*;
#(
  parameter int DEPTH  = ROB_DEPTH,
  parameter int TAG_W  = ROB_TAG_W,
  parameter int PREG_W = pipeline_types::PREG_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alloc_valid,
  output logic              alloc_ready,
  input  logic [4:0]        alloc_rd_log,
  input  logic [PREG_W-1:0] alloc_rd_phys,
  input  logic [PREG_W-1:0] alloc_rd_old_phys,
  input  logic              alloc_reg_write,
  input  logic              alloc_is_branch,
  input  logic [31:0]       alloc_pc,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              wb_valid,
  input  logic [TAG_W-1:0]  wb_tag,
  input  logic              wb_mispredict,
  output logic              commit_valid,
  output logic [4:0]        commit_rd_log,
  output logic [PREG_W-1:0] commit_rd_phys,
  output logic [PREG_W-1:0] commit_rd_old_phys,
  output logic              commit_reg_write,
  output logic [31:0]       commit_pc,
  output logic              flush_valid,
  output logic [31:0]       flush_pc
`ifdef ROB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_commit_cnt,
  output logic [31:0]       perf_flush_cnt,
  output logic [31:0]       perf_full_cycles
`endif
);

  localparam logic [TAG_W:0] FULL_COUNT = (TAG_W+1)'(DEPTH);

  rob_entry_t       rob_q [DEPTH];
  logic [TAG_W-1:0] head_q;
  logic [TAG_W-1:0] tail_q;
  logic [TAG_W:0]   count_q;

  rob_entry_t head_e;
  logic       head_commit;
  logic       alloc_fire;
  logic       wb_fire;

  // Outputs are forced to their idle values while reset is high so the
  // pipeline sees a clean, empty buffer even before the reset edge lands.
  always_comb begin
    head_e      = rob_q[head_q];
    head_commit = !reset && head_e.valid && head_e.done;

    commit_valid       = head_commit;
    commit_rd_log      = head_commit ? head_e.rd_log      : '0;
    commit_rd_phys     = head_commit ? head_e.rd_phys     : '0;
    commit_rd_old_phys = head_commit ? head_e.rd_old_phys : '0;
    commit_reg_write   = head_commit ? head_e.reg_write   : 1'b0;
    commit_pc          = head_commit ? head_e.pc          : '0;

    flush_valid = head_commit && head_e.mispredicted;
    flush_pc    = flush_valid ? head_e.pc : '0;

    // No commit bypass: a full buffer stalls allocation even if the head
    // retires in the same cycle.
    alloc_ready = reset || (count_q != FULL_COUNT);
    alloc_tag   = reset ? '0 : tail_q;

    alloc_fire = alloc_valid && alloc_ready && !flush_valid;
    wb_fire    = wb_valid && rob_q[wb_tag].valid && !flush_valid;
  end

  // Entry array and pointers. Flush wins over everything else; otherwise
  // alloc, writeback and commit touch disjoint fields or slots (alloc only
  // writes an invalid slot, writeback only a valid one), and the commit
  // clear of valid is ordered last.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        rob_q[i].valid        <= 1'b0;
        rob_q[i].done         <= 1'b0;
        rob_q[i].mispredicted <= 1'b0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush_valid) begin
      for (int i = 0; i < DEPTH; i++) begin
        rob_q[i].valid        <= 1'b0;
        rob_q[i].done         <= 1'b0;
        rob_q[i].mispredicted <= 1'b0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (alloc_fire) begin
        rob_q[tail_q].valid        <= 1'b1;
        rob_q[tail_q].done         <= 1'b0;
        rob_q[tail_q].mispredicted <= 1'b0;
        rob_q[tail_q].is_branch    <= alloc_is_branch;
        rob_q[tail_q].reg_write    <= alloc_reg_write;
        rob_q[tail_q].rd_log       <= alloc_rd_log;
        rob_q[tail_q].rd_phys      <= alloc_rd_phys;
        rob_q[tail_q].rd_old_phys  <= alloc_rd_old_phys;
        rob_q[tail_q].pc           <= alloc_pc;
        tail_q                     <= tail_q + 1'b1;
      end
      if (wb_fire) begin
        rob_q[wb_tag].done         <= 1'b1;
        rob_q[wb_tag].mispredicted <= rob_q[wb_tag].mispredicted
                                      | (wb_mispredict & rob_q[wb_tag].is_branch);
      end
      if (head_commit) begin
        rob_q[head_q].valid <= 1'b0;
        head_q              <= head_q + 1'b1;
      end
      if (alloc_fire && !head_commit)
        count_q <= count_q + 1'b1;
      else if (!alloc_fire && head_commit)
        count_q <= count_q - 1'b1;
    end
  end

`ifdef ROB_PERF_CNT_EN
  // Saturating event counters; they hold at all-ones rather than wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_commit_cnt  <= '0;
      perf_flush_cnt   <= '0;
      perf_full_cycles <= '0;
    end else begin
      if (head_commit && perf_commit_cnt != '1)
        perf_commit_cnt <= perf_commit_cnt + 1'b1;
      if (flush_valid && perf_flush_cnt != '1)
        perf_flush_cnt <= perf_flush_cnt + 1'b1;
      if (count_q == FULL_COUNT && perf_full_cycles != '1)
        perf_full_cycles <= perf_full_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed self-checking bench for reorder_buffer
// (default build, ROB_PERF_CNT_EN undefined). Inputs change 1ns after the
// rising edge; outputs are checked 1ns later, well away from the edge.
module tb_reorder_buffer;

  logic        clk;
  logic        reset;
  logic        alloc_valid;
  logic        alloc_ready;
  logic [4:0]  alloc_rd_log;
  logic [5:0]  alloc_rd_phys;
  logic [5:0]  alloc_rd_old_phys;
  logic        alloc_reg_write;
  logic        alloc_is_branch;
  logic [31:0] alloc_pc;
  logic [3:0]  alloc_tag;
  logic        wb_valid;
  logic [3:0]  wb_tag;
  logic        wb_mispredict;
  logic        commit_valid;
  logic [4:0]  commit_rd_log;
  logic [5:0]  commit_rd_phys;
  logic [5:0]  commit_rd_old_phys;
  logic        commit_reg_write;
  logic [31:0] commit_pc;
  logic        flush_valid;
  logic [31:0] flush_pc;

  int tests_run;
  int tests_failed;

  reorder_buffer dut (
    .clk                (clk),
    .reset              (reset),
    .alloc_valid        (alloc_valid),
    .alloc_ready        (alloc_ready),
    .alloc_rd_log       (alloc_rd_log),
    .alloc_rd_phys      (alloc_rd_phys),
    .alloc_rd_old_phys  (alloc_rd_old_phys),
    .alloc_reg_write    (alloc_reg_write),
    .alloc_is_branch    (alloc_is_branch),
    .alloc_pc           (alloc_pc),
    .alloc_tag          (alloc_tag),
    .wb_valid           (wb_valid),
    .wb_tag             (wb_tag),
    .wb_mispredict      (wb_mispredict),
    .commit_valid       (commit_valid),
    .commit_rd_log      (commit_rd_log),
    .commit_rd_phys     (commit_rd_phys),
    .commit_rd_old_phys (commit_rd_old_phys),
    .commit_reg_write   (commit_reg_write),
    .commit_pc          (commit_pc),
    .flush_valid        (flush_valid),
    .flush_pc           (flush_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance to 1ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction to the allocation port. Register fields are
  // derived from the PC so commit data can be predicted by hand.
  task automatic applyStimulus(input logic valid, input logic [31:0] pc,
                               input logic is_branch);
    alloc_valid       = valid;
    alloc_pc          = pc;
    alloc_is_branch   = is_branch;
    alloc_reg_write   = !is_branch;
    alloc_rd_log      = pc[6:2];
    alloc_rd_phys     = 6'(pc[7:2] + 6'd1);
    alloc_rd_old_phys = 6'(pc[7:2] + 6'd10);
  endtask

  task automatic applyWb(input logic valid, input logic [3:0] tag,
                         input logic mispredict);
    wb_valid      = valid;
    wb_tag        = tag;
    wb_mispredict = mispredict;
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0);
    applyWb(1'b0, 4'd0, 1'b0);
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0);
    applyWb(1'b0, 4'd0, 1'b0);

    // Reset state
    doReset();
    #1;
    checkOutput("rst_alloc_ready",  32'(alloc_ready),  32'd1);
    checkOutput("rst_alloc_tag",    32'(alloc_tag),    32'd0);
    checkOutput("rst_commit_valid", 32'(commit_valid), 32'd0);
    checkOutput("rst_flush_valid",  32'(flush_valid),  32'd0);
    checkOutput("rst_commit_pc",    commit_pc,         32'd0);

    // Three allocations, out-of-order writeback, in-order commit
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'(4 * i), 1'b0);
      #1;
      checkOutput("t1_alloc_tag", 32'(alloc_tag), 32'(i));
      step();
    end
    applyStimulus(1'b0, 32'h0, 1'b0);
    applyWb(1'b1, 4'd2, 1'b0);
    #1;
    checkOutput("t1_no_commit_wb2", 32'(commit_valid), 32'd0);
    step();
    applyWb(1'b1, 4'd0, 1'b0);
    #1;
    checkOutput("t1_no_commit_wb0", 32'(commit_valid), 32'd0);
    step();
    applyWb(1'b1, 4'd1, 1'b0);
    #1;
    checkOutput("t1_commit0_valid", 32'(commit_valid), 32'd1);
    checkOutput("t1_commit0_pc",    commit_pc,         32'h0);
    step();
    applyWb(1'b0, 4'd0, 1'b0);
    #1;
    checkOutput("t1_commit1_valid",  32'(commit_valid),       32'd1);
    checkOutput("t1_commit1_pc",     commit_pc,               32'h4);
    checkOutput("t1_commit1_oldphy", 32'(commit_rd_old_phys), 32'd11);
    checkOutput("t1_commit1_phys",   32'(commit_rd_phys),     32'd2);
    checkOutput("t1_commit1_log",    32'(commit_rd_log),      32'd1);
    checkOutput("t1_commit1_rw",     32'(commit_reg_write),   32'd1);
    step();
    #1;
    checkOutput("t1_commit2_pc", commit_pc, 32'h8);
    step();
    #1;
    checkOutput("t1_empty_commit", 32'(commit_valid), 32'd0);
    checkOutput("t1_empty_data",   32'(commit_rd_old_phys), 32'd0);

    // Fill to 16, stall the 17th, wrap the tail after one commit
    doReset();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 32'h100 + 32'(4 * i), 1'b0);
      #1;
      checkOutput("t2_fill_tag",   32'(alloc_tag),   32'(i));
      checkOutput("t2_fill_ready", 32'(alloc_ready), 32'd1);
      step();
    end
    applyStimulus(1'b1, 32'h200, 1'b0);
    #1;
    checkOutput("t2_full_ready", 32'(alloc_ready), 32'd0);
    step();
    checkOutput("t2_full_count", 32'(dut.count_q), 32'd16);
    applyWb(1'b1, 4'd0, 1'b0);
    step();
    applyWb(1'b0, 4'd0, 1'b0);
    #1;
    checkOutput("t3_commit_valid", 32'(commit_valid), 32'd1);
    checkOutput("t3_commit_pc",    commit_pc,         32'h100);
    checkOutput("t3_no_bypass",    32'(alloc_ready),  32'd0);
    step();
    #1;
    checkOutput("t3_count_15",   32'(dut.count_q), 32'd15);
    checkOutput("t2_ready_back", 32'(alloc_ready), 32'd1);
    checkOutput("t2_wrap_tag",   32'(alloc_tag),   32'd0);
    step();
    #1;
    checkOutput("t2_refull_ready", 32'(alloc_ready),   32'd0);
    checkOutput("t2_refull_count", 32'(dut.count_q),   32'd16);
    applyStimulus(1'b0, 32'h0, 1'b0);

    // Mispredicted branch at tag 3; non-branch mispredict ignored
    doReset();
    for (int i = 0; i < 7; i++) begin
      if (i == 3) applyStimulus(1'b1, 32'h40, 1'b1);
      else if (i < 3) applyStimulus(1'b1, 32'h10 + 32'(4 * i), 1'b0);
      else applyStimulus(1'b1, 32'h44 + 32'(4 * (i - 4)), 1'b0);
      step();
    end
    applyStimulus(1'b0, 32'h0, 1'b0);
    applyWb(1'b1, 4'd3, 1'b1);
    step();
    applyWb(1'b1, 4'd0, 1'b0);
    step();
    applyWb(1'b1, 4'd1, 1'b1);
    #1;
    checkOutput("t4_c0_pc",    commit_pc,         32'h10);
    checkOutput("t4_c0_flush", 32'(flush_valid),  32'd0);
    step();
    applyWb(1'b1, 4'd2, 1'b0);
    #1;
    checkOutput("t4_nb_mispred_pc",    commit_pc,        32'h14);
    checkOutput("t4_nb_mispred_flush", 32'(flush_valid), 32'd0);
    step();
    applyWb(1'b0, 4'd0, 1'b0);
    #1;
    checkOutput("t4_c2_pc",    commit_pc,        32'h18);
    checkOutput("t4_c2_flush", 32'(flush_valid), 32'd0);
    step();
    applyStimulus(1'b1, 32'h300, 1'b0);
    #1;
    checkOutput("t4_flush_valid",  32'(flush_valid),  32'd1);
    checkOutput("t4_flush_pc",     flush_pc,          32'h40);
    checkOutput("t4_branch_commit", 32'(commit_valid), 32'd1);
    checkOutput("t4_branch_rw",    32'(commit_reg_write), 32'd0);
    step();
    applyStimulus(1'b0, 32'h0, 1'b0);
    #1;
    checkOutput("t4_flush_pulse",  32'(flush_valid),   32'd0);
    checkOutput("t4_post_tag",     32'(alloc_tag),     32'd0);
    checkOutput("t4_post_commit",  32'(commit_valid),  32'd0);
    checkOutput("t4_post_count",   32'(dut.count_q),   32'd0);

    // Writeback to an invalid tag changes nothing
    applyWb(1'b1, 4'd5, 1'b0);
    step();
    applyWb(1'b0, 4'd0, 1'b0);
    applyStimulus(1'b1, 32'h500, 1'b0);
    step();
    applyStimulus(1'b0, 32'h0, 1'b0);
    #1;
    checkOutput("t5_invalid_wb_count",  32'(dut.count_q),  32'd1);
    checkOutput("t5_invalid_wb_commit", 32'(commit_valid), 32'd0);
    step();
    checkOutput("t5_tail_entry_not_done", 32'(commit_valid), 32'd0);

    // Reset with five entries in flight, head already done
    doReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 32'h600 + 32'(4 * i), 1'b0);
      step();
    end
    applyStimulus(1'b0, 32'h0, 1'b0);
    applyWb(1'b1, 4'd0, 1'b0);
    step();
    applyWb(1'b0, 4'd0, 1'b0);
    reset = 1'b1;
    #1;
    checkOutput("t6_during_rst_commit", 32'(commit_valid), 32'd0);
    checkOutput("t6_during_rst_tag",    32'(alloc_tag),    32'd0);
    step();
    reset = 1'b0;
    #1;
    checkOutput("t6_count",        32'(dut.count_q),  32'd0);
    checkOutput("t6_commit_valid", 32'(commit_valid), 32'd0);
    checkOutput("t6_alloc_tag",    32'(alloc_tag),    32'd0);
    checkOutput("t6_alloc_ready",  32'(alloc_ready),  32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
